// File: rtl/mem_port_arb.sv
// Arbitrates fetch and data requesters onto one shared memory port, with data priority.
// Optional fetch starvation guard is compiled in with `define MEM_PORT_ARB_STARVE_GUARD_EN.
module mem_port_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        if_stall,
  output logic        d_stall
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_e;

  state_e      state_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_we_q;
  logic [3:0]  mem_be_q;
  logic        pick_d;
  logic        pick_if;

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
  localparam int CW = (STARVE_LIMIT > 7) ? $clog2(STARVE_LIMIT + 1) : 3;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_d;
  logic          starved;

  assign starved = if_req && (starve_q == LIMIT);

  always_comb begin
    pick_d  = d_req && !starved;
    pick_if = if_req && !pick_d;
  end

  // Counts data grants taken while a fetch waits; any gap in if_req resets it.
  always_comb begin
    starve_d = starve_q;
    if (!if_req)
      starve_d = '0;
    else if (state_q == IDLE && pick_if)
      starve_d = '0;
    else if (state_q == IDLE && pick_d)
      starve_d = starve_q + CW'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  always_comb begin
    pick_d  = d_req;
    pick_if = if_req && !d_req;
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_d) begin
            state_q     <= D_BUSY;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_we_q    <= d_we;
            mem_be_q    <= d_be;
          end else if (pick_if) begin
            state_q     <= IF_BUSY;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'hF;
          end
        end
        // Returning to IDLE forces one dead cycle, so a still-high requester waits.
        IF_BUSY, D_BUSY: begin
          if (mem_ready) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = mem_ready && (state_q == IF_BUSY);
  assign d_ack     = mem_ready && (state_q == D_BUSY);
  assign if_rdata  = if_ack ? mem_rdata : '0;
  assign d_rdata   = d_ack  ? mem_rdata : '0;
  assign if_stall  = if_req && !if_ack;
  assign d_stall   = d_req  && !d_ack;

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;

endmodule
